// File: rtl/meter_countdown_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | meter_countdown_if : coin/load/tick inputs and time/display outputs |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
interface meter_countdown_if #(
  parameter int TW = 14
);
  logic          tick_1hz;
  logic          add_50;
  logic          add_150;
  logic          add_200;
  logic          add_500;
  logic          load_10;
  logic          load_205;
  logic [TW-1:0] time_left;
  logic          display_on;
  logic          expired;

  modport master (
    output tick_1hz, add_50, add_150, add_200, add_500, load_10, load_205,
    input  time_left, display_on, expired
  );

  modport slave (
    input  tick_1hz, add_50, add_150, add_200, add_500, load_10, load_205,
    output time_left, display_on, expired
  );
endinterface
`default_nettype wire

// File: rtl/meter_countdown.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | meter_countdown : parking-meter seconds counter with display flash   |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module meter_countdown #(
  parameter int MAX_TIME   = 9999,
  parameter int TW         = 14,
  parameter int LOW_THRESH = 200
) (
  input  wire logic         SYS_CLK,
  input  wire logic         RST_N,
  meter_countdown_if.slave  bus
);

  localparam logic [TW:0]   c_MAX_EXT  = (TW+1)'(MAX_TIME);
  localparam logic [TW-1:0] c_MAX      = TW'(MAX_TIME);
  localparam logic [TW-1:0] c_LOW      = TW'(LOW_THRESH);
  localparam logic [TW-1:0] c_LOAD_10  = TW'(10);
  localparam logic [TW-1:0] c_LOAD_205 = TW'(205);
  localparam logic [TW:0]   c_ADD_50   = (TW+1)'(50);
  localparam logic [TW:0]   c_ADD_150  = (TW+1)'(150);
  localparam logic [TW:0]   c_ADD_200  = (TW+1)'(200);
  localparam logic [TW:0]   c_ADD_500  = (TW+1)'(500);

  typedef enum logic [1:0] {
    ST_EXPIRED = 2'd0,
    ST_LOW     = 2'd1,
    ST_NORMAL  = 2'd2
  } mode_t;

  mode_t         r_mode;
  mode_t         w_mode_next;
  logic          r_tick_d;
  logic          r_tick_q;
  logic [TW-1:0] r_time_left;
  logic          r_display_on;
  logic          w_display_next;
  logic          w_sec_pulse;
  logic          w_dec;
  logic [TW:0]   w_add_sum;
  logic [TW:0]   w_sum;
  logic [TW-1:0] w_clamped;
  logic [TW-1:0] w_next;

  assign w_sec_pulse = r_tick_d & ~r_tick_q;
  assign w_dec       = w_sec_pulse && (r_time_left != '0);

  assign w_add_sum = (bus.add_50  ? c_ADD_50  : '0)
                   + (bus.add_150 ? c_ADD_150 : '0)
                   + (bus.add_200 ? c_ADD_200 : '0)
                   + (bus.add_500 ? c_ADD_500 : '0);

  // One extra bit holds 9999 + 900 before the clamp; dec never underflows.
  assign w_sum     = {1'b0, r_time_left} - {{TW{1'b0}}, w_dec} + w_add_sum;
  assign w_clamped = (w_sum > c_MAX_EXT) ? c_MAX : w_sum[TW-1:0];
  assign w_next    = bus.load_205 ? c_LOAD_205 :
                     bus.load_10  ? c_LOAD_10  : w_clamped;

  // Mode follows the upcoming value, so every transition takes one cycle.
  always_comb begin
    w_mode_next    = ST_NORMAL;
    w_display_next = 1'b1;
    if (w_next == '0) begin
      w_mode_next    = ST_EXPIRED;
      w_display_next = r_tick_d;
    end else if (w_next < c_LOW) begin
      w_mode_next    = ST_LOW;
      w_display_next = ~w_next[0];
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tick_d     <= 1'b0;
      r_tick_q     <= 1'b0;
      r_time_left  <= '0;
      r_display_on <= 1'b0;
      r_mode       <= ST_EXPIRED;
    end else begin
      r_tick_d     <= bus.tick_1hz;
      r_tick_q     <= r_tick_d;
      r_time_left  <= w_next;
      r_display_on <= w_display_next;
      r_mode       <= w_mode_next;
    end
  end

  assign bus.time_left  = r_time_left;
  assign bus.display_on = r_display_on;
  assign bus.expired    = (r_mode == ST_EXPIRED);

endmodule
`default_nettype wire

// File: tb/tb_meter_countdown.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_meter_countdown : randomized bench against a seconds-level model  |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module tb_meter_countdown;
  localparam int TW       = 14;
  localparam int MAX_TIME = 9999;
  localparam int LOW      = 200;
  localparam int HALF     = 8;

  logic SYS_CLK = 1'b0;
  logic RST_N   = 1'b0;

  meter_countdown_if #(.TW(TW)) bus();

  meter_countdown #(.MAX_TIME(MAX_TIME), .TW(TW), .LOW_THRESH(LOW)) u_dut (
    .SYS_CLK (SYS_CLK),
    .RST_N   (RST_N),
    .bus     (bus.slave)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int total = 0;
  int bad   = 0;

  // Reference: seconds value, expected display, and the last two tick samples.
  int m_val;
  bit m_disp;
  bit h1, h2;
  bit tick_en;
  int tick_cnt;

  task automatic model_reset();
    m_val = 0; m_disp = 0; h1 = 0; h2 = 0;
  endtask

  task automatic clear_pulses();
    bus.add_50 = 0; bus.add_150 = 0; bus.add_200 = 0; bus.add_500 = 0;
    bus.load_10 = 0; bus.load_205 = 0;
  endtask

  function automatic bit sp_next();
    return h1 && !h2;
  endfunction

  task automatic step();
    int adds;
    bit sp;
    @(posedge SYS_CLK);
    if (!RST_N) begin
      model_reset();
    end else begin
      sp   = h1 && !h2;
      adds = (bus.add_50 ? 50 : 0) + (bus.add_150 ? 150 : 0)
           + (bus.add_200 ? 200 : 0) + (bus.add_500 ? 500 : 0);
      if (bus.load_205)     m_val = 205;
      else if (bus.load_10) m_val = 10;
      else begin
        if (sp && m_val > 0) m_val = m_val - 1;
        m_val = m_val + adds;
        if (m_val > MAX_TIME) m_val = MAX_TIME;
      end
      if (m_val == 0)        m_disp = h1;
      else if (m_val < LOW)  m_disp = (m_val % 2 == 0);
      else                   m_disp = 1;
      h2 = h1;
      h1 = bus.tick_1hz;
    end
    #1;
    clear_pulses();
    if (tick_en) begin
      tick_cnt++;
      bus.tick_1hz = ((tick_cnt / HALF) % 2) == 1;
    end
  endtask

  task automatic test_reset();
    RST_N = 0; tick_en = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (bus.time_left !== 14'd0 || bus.expired !== 1'b1 || bus.display_on !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: got t=%0d e=%b d=%b want 0 1 0", bus.time_left, bus.expired, bus.display_on);
      end
    end
    RST_N = 1;
    for (int i = 0; i < 48; i++) begin
      step();
      total++;
      if (bus.time_left !== 14'd0 || bus.expired !== 1'b1 || bus.display_on !== m_disp) begin
        bad++;
        $display("FAIL reset_blink: got t=%0d e=%b d=%b want 0 1 %b", bus.time_left, bus.expired, bus.display_on, m_disp);
      end
    end
  endtask

  task automatic test_countdown();
    bus.load_10 = 1;
    step();
    total++;
    if (bus.time_left !== 14'd10 || bus.expired !== 1'b0 || bus.display_on !== 1'b1) begin
      bad++;
      $display("FAIL load_10: got t=%0d e=%b d=%b want 10 0 1", bus.time_left, bus.expired, bus.display_on);
    end
    for (int i = 0; i < 13 * 2 * HALF; i++) begin
      step();
      total++;
      if (bus.time_left !== TW'(m_val) || bus.expired !== (m_val == 0) || bus.display_on !== m_disp) begin
        bad++;
        $display("FAIL countdown: got t=%0d e=%b d=%b want %0d %b %b", bus.time_left, bus.expired, bus.display_on, m_val, m_val == 0, m_disp);
      end
    end
    total++;
    if (bus.time_left !== 14'd0 || bus.expired !== 1'b1) begin
      bad++;
      $display("FAIL countdown_end: got t=%0d e=%b want 0 1", bus.time_left, bus.expired);
    end
  endtask

  task automatic test_saturation();
    tick_en = 0;
    for (int i = 0; i < 20; i++) begin
      bus.add_500 = 1;
      step();
      total++;
      if (bus.time_left !== TW'(m_val)) begin
        bad++;
        $display("FAIL add500_ramp: got t=%0d want %0d", bus.time_left, m_val);
      end
    end
    total++;
    if (bus.time_left !== 14'd9999) begin
      bad++;
      $display("FAIL sat_9999: got t=%0d want 9999", bus.time_left);
    end
    tick_en = 1;
    for (int i = 0; i < 600 && m_val != 9990; i++) step();
    total++;
    if (bus.time_left !== 14'd9990) begin
      bad++;
      $display("FAIL reach_9990: got t=%0d want 9990", bus.time_left);
    end
    bus.add_50 = 1;
    step();
    total++;
    if (bus.time_left !== 14'd9999) begin
      bad++;
      $display("FAIL sat_9990_add50: got t=%0d want 9999", bus.time_left);
    end
    for (int i = 0; i < 40 && !sp_next(); i++) step();
    bus.add_500 = 1;
    step();
    total++;
    if (bus.time_left !== 14'd9999) begin
      bad++;
      $display("FAIL sat_dec_add500: got t=%0d want 9999", bus.time_left);
    end
    for (int i = 0; i < 600 && m_val != 9980; i++) step();
    bus.add_50 = 1; bus.add_150 = 1;
    step();
    total++;
    if (bus.time_left !== 14'd9999 || bus.display_on !== 1'b1) begin
      bad++;
      $display("FAIL sat_9980_combo: got t=%0d d=%b want 9999 1", bus.time_left, bus.display_on);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 40 && !sp_next(); i++) step();
    bus.load_205 = 1; bus.load_10 = 1; bus.add_500 = 1;
    step();
    total++;
    if (bus.time_left !== 14'd205 || bus.expired !== 1'b0 || bus.display_on !== 1'b1) begin
      bad++;
      $display("FAIL priority: got t=%0d e=%b d=%b want 205 0 1", bus.time_left, bus.expired, bus.display_on);
    end
  endtask

  task automatic test_low_flash();
    for (int i = 0; i < 400 && m_val != 195; i++) begin
      step();
      total++;
      if (bus.time_left !== TW'(m_val) || bus.display_on !== m_disp) begin
        bad++;
        $display("FAIL low_flash: got t=%0d d=%b want %0d %b", bus.time_left, bus.display_on, m_val, m_disp);
      end
    end
    total++;
    if (bus.time_left !== 14'd195 || bus.display_on !== 1'b0) begin
      bad++;
      $display("FAIL low_195: got t=%0d d=%b want 195 0", bus.time_left, bus.display_on);
    end
    bus.add_200 = 1;
    step();
    total++;
    if (bus.time_left !== 14'd395 || bus.display_on !== 1'b1) begin
      bad++;
      $display("FAIL low_add200: got t=%0d d=%b want 395 1", bus.time_left, bus.display_on);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      total++;
      if (bus.display_on !== 1'b1) begin
        bad++;
        $display("FAIL normal_steady: got d=%b want 1", bus.display_on);
      end
    end
  endtask

  task automatic test_coincident();
    bus.load_205 = 1;
    step();
    for (int i = 0; i < 2000 && m_val != 100; i++) begin
      step();
      total++;
      if (bus.time_left !== TW'(m_val) || bus.expired !== (m_val == 0) || bus.display_on !== m_disp) begin
        bad++;
        $display("FAIL run_to_100: got t=%0d e=%b d=%b want %0d %b %b", bus.time_left, bus.expired, bus.display_on, m_val, m_val == 0, m_disp);
      end
    end
    for (int i = 0; i < 40 && !sp_next(); i++) step();
    bus.add_50 = 1;
    step();
    total++;
    if (bus.time_left !== 14'd149) begin
      bad++;
      $display("FAIL dec_add50: got t=%0d want 149", bus.time_left);
    end
    #2 RST_N = 0;
    #1;
    total++;
    if (bus.time_left !== 14'd0 || bus.expired !== 1'b1 || bus.display_on !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got t=%0d e=%b d=%b want 0 1 0", bus.time_left, bus.expired, bus.display_on);
    end
    model_reset();
    step();
    RST_N = 1;
    for (int i = 0; i < 40 && !sp_next(); i++) step();
    bus.add_50 = 1;
    step();
    total++;
    if (bus.time_left !== 14'd50 || bus.expired !== 1'b0) begin
      bad++;
      $display("FAIL zero_add50: got t=%0d e=%b want 50 0", bus.time_left, bus.expired);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.add_50   = ($urandom_range(1023) == 0);
      bus.add_150  = ($urandom_range(1023) == 0);
      bus.add_200  = ($urandom_range(1023) == 0);
      bus.add_500  = ($urandom_range(1023) == 0);
      bus.load_10  = ($urandom_range(199) == 0);
      bus.load_205 = ($urandom_range(399) == 0);
      step();
      total++;
      if (bus.time_left !== TW'(m_val) || bus.expired !== (m_val == 0) || bus.display_on !== m_disp) begin
        bad++;
        $display("FAIL random: got t=%0d e=%b d=%b want %0d %b %b", bus.time_left, bus.expired, bus.display_on, m_val, m_val == 0, m_disp);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick_1hz = 0;
    clear_pulses();
    tick_en  = 0;
    tick_cnt = 0;
    model_reset();
    test_reset();
    test_countdown();
    test_saturation();
    test_priority();
    test_low_flash();
    test_coincident();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
